// File: rtl/matmul_sequencer_if.sv
// Control/status and PE-array handshake bundle for matmul_sequencer.
// master = control register / buffer side, slave = the sequencer.
interface matmul_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             mode_i;
    logic [1:0]       dim_n_i;
    logic [1:0]       dim_k_i;
    logic [1:0]       dim_m_i;
    logic             stall_i;
    logic             wr_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             issue_valid_o;
    logic [1:0]       k_idx_o;
    logic             pe_clear_o;
    logic             wr_en_o;
    logic [1:0]       wr_row_o;
    logic [1:0]       wr_col_o;
    logic             acc_mode_o;
    logic [CNT_W-1:0] perf_cycles_o;

    modport master (
        output start_i, mode_i, dim_n_i, dim_k_i, dim_m_i, stall_i, wr_ready_i,
        input  busy_o, done_o, err_o, issue_valid_o, k_idx_o, pe_clear_o,
               wr_en_o, wr_row_o, wr_col_o, acc_mode_o, perf_cycles_o
    );

    modport slave (
        input  start_i, mode_i, dim_n_i, dim_k_i, dim_m_i, stall_i, wr_ready_i,
        output busy_o, done_o, err_o, issue_valid_o, k_idx_o, pe_clear_o,
               wr_en_o, wr_row_o, wr_col_o, acc_mode_o, perf_cycles_o
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences one N x K x M matrix-multiply job: operand issue, pipeline drain, result write-back.
// Optional job cycle counter enabled by defining SEQ_PERF_CNT_EN.
module matmul_sequencer #(
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    matmul_sequencer_if.slave   bus
);

    if (PIPE_LAT < 1 || PIPE_LAT > 15) begin : g_bad_lat
        $error("matmul_sequencer: PIPE_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_LAST = 4'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        DRAIN   = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Dimensions stay in the dim-1 encoding so "last index" is a direct compare.
    typedef struct packed {
        logic       mode;
        logic [1:0] n;
        logic [1:0] k;
        logic [1:0] m;
    } cfg_t;

    state_e     state_q, state_d;
    cfg_t       cfg_q;
    logic [1:0] k_cnt_q;
    logic [3:0] lat_cnt_q;
    logic [1:0] row_q, col_q;

    logic start_acc;
    logic issue;
    logic k_last;
    logic wr_acc;
    logic wr_last;
    logic busy;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        issue     = 1'b0;
        k_last    = 1'b0;
        wr_acc    = 1'b0;
        wr_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    start_acc = 1'b1;
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                issue  = !bus.stall_i;
                k_last = (k_cnt_q == cfg_q.k);
                if (issue && k_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (lat_cnt_q == LAT_LAST) state_d = WRITE;
            end
            WRITE: begin
                wr_acc  = bus.wr_ready_i;
                wr_last = (row_q == cfg_q.n) && (col_q == cfg_q.m);
                if (wr_acc && wr_last) state_d = DONE;
            end
            DONE: begin
                // start_i here is deliberately ignored; a held level is taken next cycle in IDLE
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_q     <= '0;
            k_cnt_q   <= '0;
            lat_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            if (start_acc) begin
                cfg_q   <= '{mode: bus.mode_i, n: bus.dim_n_i, k: bus.dim_k_i, m: bus.dim_m_i};
                k_cnt_q <= '0;
            end else if (issue) begin
                k_cnt_q <= k_last ? 2'd0 : k_cnt_q + 2'd1;
            end

            if (state_q == DRAIN) lat_cnt_q <= lat_cnt_q + 4'd1;
            else                  lat_cnt_q <= '0;

            // Row-major walk, column fastest; only accepted writes advance it.
            if (state_q == DRAIN) begin
                row_q <= '0;
                col_q <= '0;
            end else if (wr_acc) begin
                if (col_q == cfg_q.m) begin
                    col_q <= '0;
                    row_q <= row_q + 2'd1;
                end else begin
                    col_q <= col_q + 2'd1;
                end
            end
        end
    end

    assign busy              = (state_q != IDLE);
    assign bus.busy_o        = busy;
    assign bus.done_o        = (state_q == DONE);
    assign bus.err_o         = bus.start_i &&
                               (state_q == COMPUTE || state_q == DRAIN || state_q == WRITE);
    assign bus.issue_valid_o = issue;
    assign bus.k_idx_o       = (state_q == COMPUTE) ? k_cnt_q : 2'd0;
    assign bus.pe_clear_o    = issue && (k_cnt_q == 2'd0) && !cfg_q.mode;
    assign bus.wr_en_o       = (state_q == WRITE);
    assign bus.wr_row_o      = (state_q == WRITE) ? row_q : 2'd0;
    assign bus.wr_col_o      = (state_q == WRITE) ? col_q : 2'd0;
    assign bus.acc_mode_o    = cfg_q.mode;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_inc, perf_q;

    assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);

    // The DONE-cycle snapshot uses cyc_inc so the DONE cycle itself is counted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_q  <= '0;
            perf_q <= '0;
        end else begin
            if (start_acc)  cyc_q <= '0;
            else if (busy)  cyc_q <= cyc_inc;
            if (state_q == DONE) perf_q <= cyc_inc;
        end
    end

    assign bus.perf_cycles_o = perf_q;
`else
    assign bus.perf_cycles_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: stimulus pushes expectations, a negedge monitor pops and checks.
module tb_matmul_sequencer;
    localparam int PIPE_LAT = 2;
    localparam int CNT_W    = 16;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    matmul_sequencer_if #(.CNT_W(CNT_W)) bus ();

    matmul_sequencer #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct packed { logic [1:0] k; logic clr; logic acc; } iss_t;
    typedef struct packed { logic [1:0] row; logic [1:0] col; logic acc; } wr_t;
    typedef struct packed { int busy; int perf; } done_t;

    iss_t  iss_q[$];
    wr_t   wr_q[$];
    done_t done_q[$];
    int    err_q[$];

    int checks = 0, errors = 0;
    int iss_seen = 0, wr_seen = 0, done_seen = 0, err_seen = 0, busy_cnt = 0;
    bit perf_pending = 0;
    int perf_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk_i) begin
        iss_t ie; wr_t we; done_t de; int ee;
        if (!rst_ni) begin
            busy_cnt     = 0;
            perf_pending = 0;
        end else begin
            if (perf_pending) begin
                chk("perf_cycles", int'(bus.perf_cycles_o), perf_exp);
                perf_pending = 0;
            end
            if (bus.busy_o) busy_cnt++;
            if (bus.issue_valid_o) begin
                iss_seen++;
                chk("issue_expected", int'(iss_q.size() > 0), 1);
                if (iss_q.size() > 0) begin
                    ie = iss_q.pop_front();
                    chk("k_idx", int'(bus.k_idx_o), int'(ie.k));
                    chk("pe_clear", int'(bus.pe_clear_o), int'(ie.clr));
                    chk("acc_mode_issue", int'(bus.acc_mode_o), int'(ie.acc));
                end
            end
            if (bus.wr_en_o && bus.wr_ready_i) begin
                wr_seen++;
                chk("write_expected", int'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    we = wr_q.pop_front();
                    chk("wr_row", int'(bus.wr_row_o), int'(we.row));
                    chk("wr_col", int'(bus.wr_col_o), int'(we.col));
                    chk("acc_mode_write", int'(bus.acc_mode_o), int'(we.acc));
                end
            end
            if (bus.err_o) begin
                err_seen++;
                chk("err_expected", int'(err_q.size() > 0), 1);
                if (err_q.size() > 0) ee = err_q.pop_front();
            end
            if (bus.done_o) begin
                done_seen++;
                chk("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    de = done_q.pop_front();
                    chk("busy_len", busy_cnt, de.busy);
                    perf_exp     = de.perf;
                    perf_pending = 1;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  int'(bus.busy_o), 0);
        chk({tag, "_done"},  int'(bus.done_o), 0);
        chk({tag, "_err"},   int'(bus.err_o), 0);
        chk({tag, "_issue"}, int'(bus.issue_valid_o), 0);
        chk({tag, "_kidx"},  int'(bus.k_idx_o), 0);
        chk({tag, "_clear"}, int'(bus.pe_clear_o), 0);
        chk({tag, "_wren"},  int'(bus.wr_en_o), 0);
        chk({tag, "_row"},   int'(bus.wr_row_o), 0);
        chk({tag, "_col"},   int'(bus.wr_col_o), 0);
        chk({tag, "_acc"},   int'(bus.acc_mode_o), 0);
        chk({tag, "_perf"},  int'(bus.perf_cycles_o), 0);
    endtask

    task automatic push_expect(input int n, input int k, input int m, input bit mode, input int busy_len);
        for (int i = 0; i <= k; i++)
            iss_q.push_back('{k: 2'(i), clr: (i == 0 && !mode), acc: mode});
        for (int r = 0; r <= n; r++)
            for (int c = 0; c <= m; c++)
                wr_q.push_back('{row: 2'(r), col: 2'(c), acc: mode});
`ifdef SEQ_PERF_CNT_EN
        done_q.push_back('{busy: busy_len, perf: busy_len});
`else
        done_q.push_back('{busy: busy_len, perf: 0});
`endif
    endtask

    // One start pulse, then config inputs are scrambled to show they are not re-sampled.
    task automatic pulse_start(input int n, input int k, input int m, input bit mode);
        @(posedge clk_i); #1;
        bus.start_i = 1'b1;
        bus.dim_n_i = 2'(n); bus.dim_k_i = 2'(k); bus.dim_m_i = 2'(m); bus.mode_i = mode;
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        bus.dim_n_i = ~2'(n); bus.dim_k_i = ~2'(k); bus.dim_m_i = ~2'(m); bus.mode_i = !mode;
    endtask

    task automatic run_job(input int n, input int k, input int m, input bit mode,
                           input int stall_len, input int rdy_len, input bit err_inj, input int busy_len);
        int bi, bw, bd, be, cyc, sc, rc;
        bit ed;
        push_expect(n, k, m, mode, busy_len);
        bi = iss_seen; bw = wr_seen; bd = done_seen; be = err_seen;
        cyc = 0; sc = 0; rc = 0; ed = 0;
        pulse_start(n, k, m, mode);
        while (done_seen == bd && cyc < 300) begin
            bus.stall_i    = (iss_seen == bi + 1) && (sc < stall_len);
            if (bus.stall_i) sc++;
            bus.wr_ready_i = !((wr_seen == bw + 1) && (rc < rdy_len));
            if (!bus.wr_ready_i) rc++;
            bus.start_i = 1'b0;
            if (err_inj && !ed && iss_seen == bi + 1) begin
                bus.start_i = 1'b1;
                ed = 1;
                err_q.push_back(1);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        bus.start_i = 1'b0; bus.stall_i = 1'b0; bus.wr_ready_i = 1'b1;
        chk("job_finished", done_seen - bd, 1);
        repeat (2) @(negedge clk_i);
        #1;
        chk("issue_count", iss_seen - bi, k + 1);
        chk("write_count", wr_seen - bw, (n + 1) * (m + 1));
        chk("err_count", err_seen - be, err_inj ? 1 : 0);
        chk("done_count", done_seen - bd, 1);
        chk("queues_drained", iss_q.size() + wr_q.size() + done_q.size() + err_q.size(), 0);
    endtask

    task automatic run_reset_mid_write();
        int bw, bd, cyc;
        push_expect(1, 2, 1, 1'b0, 10);
        bw = wr_seen; bd = done_seen; cyc = 0;
        pulse_start(1, 2, 1, 1'b0);
        while (wr_seen < bw + 2 && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("reset_reached_write", wr_seen - bw, 2);
        rst_ni = 1'b0;
        iss_q.delete(); wr_q.delete(); done_q.delete(); err_q.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_idle("midreset");
        repeat (4) @(negedge clk_i);
        chk("midreset_no_done", done_seen - bd, 0);
        chk("midreset_no_more_writes", wr_seen - bw, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i = 1'b0; bus.mode_i = 1'b0;
        bus.dim_n_i = '0; bus.dim_k_i = '0; bus.dim_m_i = '0;
        bus.stall_i = 1'b0; bus.wr_ready_i = 1'b1;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_idle("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_idle("post_reset");

        // basic: N=2 K=3 M=2, 3 + 2 + 4 + 1 = 10 busy cycles
        run_job(1, 2, 1, 1'b0, 0, 0, 1'b0, 10);
        // backpressure: 2 stall cycles + 3 not-ready cycles on top of 10
        run_job(1, 2, 1, 1'b0, 2, 3, 1'b0, 15);
        // accumulate 1x1x1: 1 + 2 + 1 + 1
        run_job(0, 0, 0, 1'b1, 0, 0, 1'b0, 5);
        // start while busy in COMPUTE: err pulse, job unchanged
        run_job(1, 2, 1, 1'b0, 0, 0, 1'b1, 10);
        run_reset_mid_write();
        run_job(1, 2, 1, 1'b0, 0, 0, 1'b0, 10);
        // max dims: 4 + 2 + 16 + 1
        run_job(3, 3, 3, 1'b0, 0, 0, 1'b0, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
